// File: rtl/router_pkg.sv
// Shared constants, state encoding and header packing for the router packet source.
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY
  } tx_state_t;

  function automatic logic [DATA_W-1:0] pack_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] dest
  );
    return {len, dest};
  endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Payload store: one synchronous write port, one combinational read port.
module pkt_buffer
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 63
) (
  input  logic              clk,
  input  logic              i_Wr_En,
  input  logic [LEN_W-1:0]  i_Wr_Addr,
  input  logic [DATA_W-1:0] i_Wr_Data,
  input  logic [LEN_W-1:0]  i_Rd_Addr,
  output logic [DATA_W-1:0] o_Rd_Data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; only indices below the latched length are ever read.
  always_ff @(posedge clk) begin
    if (i_Wr_En && (i_Wr_Addr < LEN_W'(DEPTH)))
      r_mem[i_Wr_Addr] <= i_Wr_Data;
  end

  always_comb begin
    o_Rd_Data = '0;
    if (i_Rd_Addr < LEN_W'(DEPTH))
      o_Rd_Data = r_mem[i_Rd_Addr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port: buffers a payload, then frames it as
// header, payload and parity while honouring router back-pressure.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_Dest,
  input  logic [LEN_W-1:0]  i_Length,
  input  logic              i_Inject_Error,
  output logic              o_Start_Ready,
  input  logic [DATA_W-1:0] i_Payload_Data,
  input  logic              i_Payload_Valid,
  output logic              o_Payload_Ready,
  input  logic              i_Sig_Busy,
  output logic              o_Valid_Packet,
  output logic [DATA_W-1:0] o_Output_Data,
  output logic              o_Done,
  output logic              o_Reject
);

  tx_state_t         r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_k;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] r_parity;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_done;
  logic              r_reject;

  logic              w_req_ok;
  logic              w_wr_en;
  logic              w_last_load;
  logic              w_last_pay;
  logic [LEN_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_req_ok    = (i_Dest != ADDR_INVALID) && (i_Length != '0) &&
                       (i_Length <= LEN_W'(MAX_LEN));
  assign w_wr_en     = (r_state == S_LOAD) && i_Payload_Valid;
  assign w_last_load = (r_cnt == r_len - LEN_W'(1));
  assign w_last_pay  = (r_k == r_len - LEN_W'(1));
  // Read one byte ahead so the registered output can be loaded on the consuming edge.
  assign w_rd_addr   = (r_state == S_HEADER) ? '0 : r_k + LEN_W'(1);

  pkt_buffer #(.DEPTH(MAX_LEN)) u_buf (
    .clk       (clk),
    .i_Wr_En   (w_wr_en),
    .i_Wr_Addr (r_cnt),
    .i_Wr_Data (i_Payload_Data),
    .i_Rd_Addr (w_rd_addr),
    .o_Rd_Data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_k      <= '0;
      r_dest   <= '0;
      r_parity <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            if (w_req_ok) begin
              r_dest   <= i_Dest;
              r_len    <= i_Length;
              r_cnt    <= '0;
              r_parity <= pack_header(i_Length, i_Dest) ^
                          {{(DATA_W-1){1'b0}}, i_Inject_Error};
              r_state  <= S_LOAD;
            end else begin
              r_reject <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (i_Payload_Valid) begin
            r_cnt    <= r_cnt + LEN_W'(1);
            r_parity <= r_parity ^ i_Payload_Data;
            if (w_last_load) begin
              r_state <= S_HEADER;
              r_valid <= 1'b1;
              r_data  <= pack_header(r_len, r_dest);
            end
          end
        end
        S_HEADER: begin
          if (!i_Sig_Busy) begin
            r_state <= S_PAYLOAD;
            r_k     <= '0;
            r_data  <= w_rd_data;
          end
        end
        S_PAYLOAD: begin
          if (!i_Sig_Busy) begin
            if (w_last_pay) begin
              r_state <= S_PARITY;
              r_valid <= 1'b0;
              r_data  <= r_parity;
            end else begin
              r_k    <= r_k + LEN_W'(1);
              r_data <= w_rd_data;
            end
          end
        end
        S_PARITY: begin
          if (!i_Sig_Busy) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_data  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Start_Ready   = (r_state == S_IDLE);
  assign o_Payload_Ready = (r_state == S_LOAD);
  assign o_Valid_Packet  = r_valid;
  assign o_Output_Data   = r_data;
  assign o_Done          = r_done;
  assign o_Reject        = r_reject;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: framing, back-pressure, rejects, reset and max length.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_Start = 1'b0;
  logic [1:0] i_Dest = '0;
  logic [5:0] i_Length = '0;
  logic       i_Inject_Error = 1'b0;
  logic       o_Start_Ready;
  logic [7:0] i_Payload_Data = '0;
  logic       i_Payload_Valid = 1'b0;
  logic       o_Payload_Ready;
  logic       i_Sig_Busy = 1'b0;
  logic       o_Valid_Packet;
  logic [7:0] o_Output_Data;
  logic       o_Done;
  logic       o_Reject;

  int checks = 0;
  int errors = 0;

  logic [7:0] pl [64];
  logic       tr_valid [512];
  logic [7:0] tr_data  [512];
  int         tr_pos   [512];
  logic       tr_done  [512];
  int         ntr;
  logic [7:0] cons [128];
  int         ncons;
  logic [7:0] par;
  bit         par_seen;
  bit         done_seen;

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_Start         (i_Start),
    .i_Dest          (i_Dest),
    .i_Length        (i_Length),
    .i_Inject_Error  (i_Inject_Error),
    .o_Start_Ready   (o_Start_Ready),
    .i_Payload_Data  (i_Payload_Data),
    .i_Payload_Valid (i_Payload_Valid),
    .o_Payload_Ready (o_Payload_Ready),
    .i_Sig_Busy      (i_Sig_Busy),
    .o_Valid_Packet  (o_Valid_Packet),
    .o_Output_Data   (o_Output_Data),
    .o_Done          (o_Done),
    .o_Reject        (o_Reject)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [1:0] dest, input logic [5:0] len, input logic inj);
    i_Start = 1'b1; i_Dest = dest; i_Length = len; i_Inject_Error = inj;
    step();
    i_Start = 1'b0; i_Inject_Error = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      i_Payload_Valid = 1'b1;
      i_Payload_Data  = pl[i];
      step();
    end
    i_Payload_Valid = 1'b0;
  endtask

  // mode 0: never busy; 1: busy hold_n cycles while output position hold_at is shown;
  // 2: busy on even cycles starting with the header cycle.
  task automatic capture(input int mode, input int hold_at, input int hold_n, input int maxcyc);
    int held;
    int pos;
    bit in_pkt;
    held = 0; pos = 0; in_pkt = 1'b1;
    ntr = 0; ncons = 0; par = '0; par_seen = 1'b0; done_seen = 1'b0;
    for (int c = 0; c < maxcyc; c++) begin
      if (mode == 1) begin
        i_Sig_Busy = (pos == hold_at) && (held < hold_n);
        if (i_Sig_Busy) held++;
      end else if (mode == 2) begin
        i_Sig_Busy = (c % 2 == 0);
      end else begin
        i_Sig_Busy = 1'b0;
      end
      @(negedge clk);
      tr_valid[ntr] = o_Valid_Packet;
      tr_data[ntr]  = o_Output_Data;
      tr_pos[ntr]   = pos;
      tr_done[ntr]  = o_Done;
      ntr++;
      if (o_Done) begin
        done_seen = 1'b1;
        break;
      end
      if (!i_Sig_Busy) begin
        if (o_Valid_Packet) begin
          cons[ncons] = o_Output_Data; ncons++; pos++;
        end else if (in_pkt) begin
          par = o_Output_Data; par_seen = 1'b1; in_pkt = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    i_Sig_Busy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_Valid_Packet !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_Valid_Packet); end
    checks++; if (o_Output_Data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h exp 00", o_Output_Data); end
    checks++; if (o_Done !== 1'b0 || o_Reject !== 1'b0) begin errors++; $display("FAIL reset_pulses got %0b%0b exp 00", o_Done, o_Reject); end
    checks++; if (o_Start_Ready !== 1'b1 || o_Payload_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 10", o_Start_Ready, o_Payload_Ready); end
    step();
  endtask

  task automatic run_basic(input logic inj, input logic [7:0] exp_par, input string nm);
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_req(2'd2, 6'd8, inj);
    @(negedge clk);
    checks++; if (o_Payload_Ready !== 1'b1 || o_Start_Ready !== 1'b0) begin errors++; $display("FAIL %s_load_ready got %0b%0b exp 10", nm, o_Payload_Ready, o_Start_Ready); end
    step();
    load(7);
    i_Payload_Valid = 1'b1; i_Payload_Data = pl[7];
    step();
    i_Payload_Valid = 1'b0;
    capture(0, 0, 0, 100);
    checks++; if (!done_seen || ntr != 11) begin errors++; $display("FAIL %s_cycles got %0d done %0b exp 11 done 1", nm, ntr, done_seen); end
    checks++; if (tr_data[0] !== 8'h22) begin errors++; $display("FAIL %s_header got %02h exp 22", nm, tr_data[0]); end
    for (int i = 1; i < 9; i++) begin
      checks++; if (tr_data[i] !== 8'(i)) begin errors++; $display("FAIL %s_byte%0d got %02h exp %02h", nm, i, tr_data[i], 8'(i)); end
    end
    for (int i = 0; i < 9; i++) begin
      checks++; if (tr_valid[i] !== 1'b1) begin errors++; $display("FAIL %s_valid%0d got %0b exp 1", nm, i, tr_valid[i]); end
    end
    checks++; if (tr_valid[9] !== 1'b0 || tr_data[9] !== exp_par) begin errors++; $display("FAIL %s_parity got v%0b %02h exp v0 %02h", nm, tr_valid[9], tr_data[9], exp_par); end
    step();
    @(negedge clk);
    checks++; if (o_Done !== 1'b0 || o_Output_Data !== 8'h00) begin errors++; $display("FAIL %s_done_once got done %0b data %02h exp 0 00", nm, o_Done, o_Output_Data); end
    step();
  endtask

  task automatic test_basic();
    run_basic(1'b0, 8'h2A, "basic");
  endtask

  task automatic test_error_inject();
    run_basic(1'b1, 8'h2B, "inject");
  endtask

  task automatic test_back_pressure();
    int hold;
    for (int i = 0; i < 5; i++) pl[i] = 8'hFF;
    send_req(2'd1, 6'd5, 1'b0);
    load(5);
    capture(1, 3, 3, 100);
    hold = 0;
    for (int i = 0; i < ntr; i++) if (tr_valid[i] && tr_pos[i] == 3) hold++;
    checks++; if (!done_seen) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++; if (ncons != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", ncons); end
    checks++; if (cons[0] !== 8'h15) begin errors++; $display("FAIL bp_header got %02h exp 15", cons[0]); end
    for (int i = 1; i < 6; i++) begin
      checks++; if (cons[i] !== 8'hFF) begin errors++; $display("FAIL bp_byte%0d got %02h exp ff", i, cons[i]); end
    end
    checks++; if (hold != 4) begin errors++; $display("FAIL bp_hold got %0d exp 4", hold); end
    checks++; if (!par_seen || par !== 8'hEA) begin errors++; $display("FAIL bp_parity got %02h exp ea", par); end
    step();
  endtask

  task automatic test_illegal();
    send_req(2'd3, 6'd4, 1'b0);
    @(negedge clk);
    checks++; if (o_Reject !== 1'b1) begin errors++; $display("FAIL rej_dest got %0b exp 1", o_Reject); end
    checks++; if (o_Start_Ready !== 1'b1 || o_Payload_Ready !== 1'b0 || o_Valid_Packet !== 1'b0) begin errors++; $display("FAIL rej_dest_state got %0b%0b%0b exp 100", o_Start_Ready, o_Payload_Ready, o_Valid_Packet); end
    step();
    @(negedge clk);
    checks++; if (o_Reject !== 1'b0) begin errors++; $display("FAIL rej_dest_pulse got %0b exp 0", o_Reject); end
    send_req(2'd0, 6'd0, 1'b0);
    @(negedge clk);
    checks++; if (o_Reject !== 1'b1) begin errors++; $display("FAIL rej_len got %0b exp 1", o_Reject); end
    checks++; if (o_Payload_Ready !== 1'b0 || o_Valid_Packet !== 1'b0) begin errors++; $display("FAIL rej_len_state got %0b%0b exp 00", o_Payload_Ready, o_Valid_Packet); end
    step();
    @(negedge clk);
    checks++; if (o_Reject !== 1'b0 || o_Payload_Ready !== 1'b0) begin errors++; $display("FAIL rej_len_pulse got %0b%0b exp 00", o_Reject, o_Payload_Ready); end
    step();
  endtask

  task automatic test_back_to_back();
    pl[0] = 8'h10; pl[1] = 8'h20;
    send_req(2'd1, 6'd2, 1'b0);
    load(2);
    capture(0, 0, 0, 50);
    checks++; if (!done_seen || !par_seen || par !== 8'h39 || cons[0] !== 8'h09) begin errors++; $display("FAIL b2b_first got hdr %02h par %02h exp 09 39", cons[0], par); end
    // Request issued in the cycle o_Done is high.
    pl[0] = 8'hA5;
    send_req(2'd2, 6'd1, 1'b0);
    @(negedge clk);
    checks++; if (o_Payload_Ready !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0b exp 1", o_Payload_Ready); end
    step();
    load(1);
    capture(0, 0, 0, 50);
    checks++; if (!done_seen || ncons != 2 || cons[0] !== 8'h06 || cons[1] !== 8'hA5) begin errors++; $display("FAIL b2b_second got n %0d %02h %02h exp 2 06 a5", ncons, cons[0], cons[1]); end
    checks++; if (par !== 8'hA3) begin errors++; $display("FAIL b2b_parity got %02h exp a3", par); end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
    send_req(2'd2, 6'd8, 1'b0);
    load(8);
    step(); step(); step();
    @(negedge clk);
    checks++; if (o_Valid_Packet !== 1'b1 || o_Output_Data !== 8'h03) begin errors++; $display("FAIL rmid_pre got v%0b %02h exp v1 03", o_Valid_Packet, o_Output_Data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (o_Valid_Packet !== 1'b0 || o_Output_Data !== 8'h00 || o_Start_Ready !== 1'b1) begin errors++; $display("FAIL rmid_post got v%0b %02h rdy %0b exp v0 00 1", o_Valid_Packet, o_Output_Data, o_Start_Ready); end
    step();
    pl[0] = 8'h55;
    send_req(2'd0, 6'd1, 1'b0);
    load(1);
    capture(0, 0, 0, 50);
    checks++; if (!done_seen || ncons != 2 || cons[0] !== 8'h04 || cons[1] !== 8'h55) begin errors++; $display("FAIL rmid_pkt got n %0d %02h %02h exp 2 04 55", ncons, cons[0], cons[1]); end
    checks++; if (par !== 8'h51) begin errors++; $display("FAIL rmid_parity got %02h exp 51", par); end
    step();
  endtask

  task automatic test_max_len();
    logic [7:0] exp_par;
    int bad;
    exp_par = 8'hFC;
    for (int i = 0; i < 63; i++) begin
      pl[i] = 8'((i * 37 + 5) % 256);
      exp_par = exp_par ^ pl[i];
    end
    send_req(2'd0, 6'd63, 1'b0);
    load(63);
    capture(2, 0, 0, 400);
    checks++; if (!done_seen || ncons != 64) begin errors++; $display("FAIL max_count got %0d done %0b exp 64 1", ncons, done_seen); end
    checks++; if (cons[0] !== 8'hFC) begin errors++; $display("FAIL max_header got %02h exp fc", cons[0]); end
    bad = 0;
    for (int i = 0; i < 63; i++) if (cons[i + 1] !== pl[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL max_order got %0d wrong bytes exp 0", bad); end
    checks++; if (par !== exp_par) begin errors++; $display("FAIL max_parity got %02h exp %02h", par, exp_par); end
    step();
    @(negedge clk);
    checks++; if (o_Done !== 1'b0) begin errors++; $display("FAIL max_done_once got %0b exp 0", o_Done); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error_inject();
    test_back_pressure();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_max_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
